// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5-8 data bits, none/odd/even parity, 1/2 stop bits.
// Oversampled at OS ticks per bit with a 3-sample majority vote around mid-bit.
module uart_rx_cfg #(
  parameter int DIV_W       = 16,
  parameter int OS          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             break_det,
  output logic             busy
);

  localparam int OS_W = $clog2(OS);
  localparam logic [OS_W-1:0] SMP_A   = OS_W'(OS / 2 - 1);
  localparam logic [OS_W-1:0] SMP_B   = OS_W'(OS / 2);
  localparam logic [OS_W-1:0] SMP_V   = OS_W'(OS / 2 + 1);
  localparam logic [OS_W-1:0] BIT_END = OS_W'(OS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]        os_cnt_q, os_cnt_d;
  logic [DIV_W-1:0]       baud_q, baud_d;
  logic [1:0]             db_q, db_d;
  logic [1:0]             par_q, par_d;
  logic                   stop2_q, stop2_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   samp_a_q, samp_a_d;
  logic                   samp_b_q, samp_b_d;
  logic                   vote_q, vote_d;
  logic                   par_acc_q, par_acc_d;
  logic                   zero_q, zero_d;
  logic                   perr_pend_q, perr_pend_d;
  logic                   ferr_pend_q, ferr_pend_d;
  logic [7:0]             data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   break_det_q, break_det_d;
  logic                   busy_q, busy_d;

  logic rx_s, fall, tick, at_a, at_b, at_v, at_end, vote_now, par_en, last_bit;
  logic fin, fin_ferr;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign fall     = prev_q & ~rx_s;
  assign tick     = (state_q != S_IDLE) && (div_cnt_q == baud_q);
  assign at_a     = tick && (os_cnt_q == SMP_A);
  assign at_b     = tick && (os_cnt_q == SMP_B);
  assign at_v     = tick && (os_cnt_q == SMP_V);
  assign at_end   = tick && (os_cnt_q == BIT_END);
  // Third sample is the live synchronised line, so the vote is usable on the SMP_V tick itself.
  assign vote_now = (samp_a_q & samp_b_q) | (samp_a_q & rx_s) | (samp_b_q & rx_s);
  assign par_en   = par_q[0] ^ par_q[1];
  assign last_bit = (bit_idx_q == (3'd4 + {1'b0, db_q}));

  always_comb begin
    state_d      = state_q;
    if (SYNC_STAGES > 1) sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    else                 sync_d = rx;
    prev_d       = rx_s;
    div_cnt_d    = div_cnt_q;
    os_cnt_d     = os_cnt_q;
    baud_d       = baud_q;
    db_d         = db_q;
    par_d        = par_q;
    stop2_d      = stop2_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    samp_a_d     = samp_a_q;
    samp_b_d     = samp_b_q;
    vote_d       = vote_q;
    par_acc_d    = par_acc_q;
    zero_d       = zero_q;
    perr_pend_d  = perr_pend_q;
    ferr_pend_d  = ferr_pend_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_det_d  = break_det_q;
    fin          = 1'b0;
    fin_ferr     = 1'b0;

    if (state_q == S_IDLE) begin
      div_cnt_d = '0;
      os_cnt_d  = '0;
    end else if (tick) begin
      div_cnt_d = '0;
      os_cnt_d  = at_end ? '0 : os_cnt_q + OS_W'(1);
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    if (at_a) samp_a_d = rx_s;
    if (at_b) samp_b_d = rx_s;
    if (at_v) vote_d   = vote_now;

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d     = S_START;
          baud_d      = baud_div;
          db_d        = cfg_data_bits;
          par_d       = cfg_parity;
          stop2_d     = cfg_stop2;
          bit_idx_d   = '0;
          shreg_d     = '0;
          par_acc_d   = 1'b0;
          zero_d      = 1'b1;
          perr_pend_d = 1'b0;
          ferr_pend_d = 1'b0;
        end
      end
      S_START: begin
        if (at_end) state_d = vote_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (at_end) begin
          shreg_d[bit_idx_q] = vote_q;
          par_acc_d          = par_acc_q ^ vote_q;
          if (vote_q) zero_d = 1'b0;
          if (last_bit) state_d = par_en ? S_PARITY : S_STOP1;
          else          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (at_end) begin
          // Odd mode wants an odd total of ones, even mode an even total.
          perr_pend_d = (par_q == 2'b01) ? ~(par_acc_q ^ vote_q) : (par_acc_q ^ vote_q);
          if (vote_q) zero_d = 1'b0;
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (stop2_q) begin
          if (at_end) begin
            if (!vote_q) ferr_pend_d = 1'b1;
            state_d = S_STOP2;
          end
        end else if (at_v) begin
          fin      = 1'b1;
          fin_ferr = ~vote_now;
        end
      end
      S_STOP2: begin
        if (at_v) begin
          fin      = 1'b1;
          fin_ferr = ferr_pend_q | ~vote_now;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Finishing on the last mid-bit vote leaves half a stop bit of slack for the next start edge.
    if (fin) begin
      state_d      = S_IDLE;
      data_valid_d = 1'b1;
      data_out_d   = shreg_q;
      parity_err_d = perr_pend_q;
      frame_err_d  = fin_ferr;
      break_det_d  = fin_ferr & zero_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sync_q       <= '1;
      prev_q       <= 1'b1;
      div_cnt_q    <= '0;
      os_cnt_q     <= '0;
      baud_q       <= '0;
      db_q         <= '0;
      par_q        <= '0;
      stop2_q      <= 1'b0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      samp_a_q     <= 1'b0;
      samp_b_q     <= 1'b0;
      vote_q       <= 1'b0;
      par_acc_q    <= 1'b0;
      zero_q       <= 1'b0;
      perr_pend_q  <= 1'b0;
      ferr_pend_q  <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      div_cnt_q    <= div_cnt_d;
      os_cnt_q     <= os_cnt_d;
      baud_q       <= baud_d;
      db_q         <= db_d;
      par_q        <= par_d;
      stop2_q      <= stop2_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      samp_a_q     <= samp_a_d;
      samp_b_q     <= samp_b_d;
      vote_q       <= vote_d;
      par_acc_q    <= par_acc_d;
      zero_q       <= zero_d;
      perr_pend_q  <= perr_pend_d;
      ferr_pend_q  <= ferr_pend_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_det_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: drives serial frames bit by bit and compares each strobe
// against a frame-level model of what the line carried.
module tb_uart_rx_cfg;

  localparam int OS    = 16;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             rx  = 1'b1;
  logic [DIV_W-1:0] baud_div = '0;
  logic [1:0]       cfg_data_bits = 2'b11;
  logic [1:0]       cfg_parity = 2'b00;
  logic             cfg_stop2 = 1'b0;
  logic [7:0]       data_out;
  logic             data_valid, parity_err, frame_err, break_det, busy;

  int checks_total  = 0;
  int checks_passed = 0;
  int cur_div       = 5;
  logic [11:0] obs_q[$];

  uart_rx_cfg #(.DIV_W(DIV_W), .OS(OS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .baud_div(baud_div),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .break_det(break_det), .busy(busy)
  );

  always #5 clk = ~clk;

  // Every strobe is recorded as {busy, break, frame, parity, data}.
  always @(negedge clk)
    if (rst && data_valid) obs_q.push_back({busy, break_det, frame_err, parity_err, data_out});

  function automatic logic [7:0] mask_data(logic [7:0] d, logic [1:0] db);
    int mask;
    mask = (1 << (int'(db) + 5)) - 1;
    return d & mask[7:0];
  endfunction

  function automatic logic parity_bit(logic [7:0] m, logic [1:0] par, logic flip);
    int ones;
    ones = $countones(m);
    if (par == 2'b01) return ((ones % 2) == 0) ^ flip;
    return ((ones % 2) == 1) ^ flip;
  endfunction

  // Expected strobe record from what the line carried.
  function automatic logic [11:0] model_frame(logic [7:0] d, logic [1:0] db, logic [1:0] par,
                                              logic st2, logic flip, logic s1, logic s2);
    logic [7:0] m;
    logic pen, pb, perr, ferr, brk;
    int total;
    m     = mask_data(d, db);
    pen   = (par == 2'b01) || (par == 2'b10);
    pb    = pen ? parity_bit(m, par, flip) : 1'b0;
    total = $countones(m) + int'(pb);
    perr  = pen && ((par == 2'b01) ? (total % 2 != 1) : (total % 2 != 0));
    ferr  = !s1 || (st2 && !s2);
    brk   = ferr && (m == 8'h00) && !pb;
    return {1'b0, brk, ferr, perr, m};
  endfunction

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] db, input logic [1:0] par,
                            input logic st2, input logic flip, input logic s1, input logic s2,
                            input int gap_bits);
    int bc;
    logic [7:0] m;
    bc            = OS * (cur_div + 1);
    m             = mask_data(d, db);
    baud_div      = DIV_W'(cur_div);
    cfg_data_bits = db;
    cfg_parity    = par;
    cfg_stop2     = st2;
    drive_bit(1'b0, bc);
    // Scramble the config mid-frame; the receiver must keep what it latched.
    baud_div      = DIV_W'($urandom);
    cfg_data_bits = 2'($urandom);
    cfg_parity    = 2'($urandom);
    cfg_stop2     = 1'($urandom);
    for (int i = 0; i < int'(db) + 5; i++) drive_bit(m[i], bc);
    if (par == 2'b01 || par == 2'b10) drive_bit(parity_bit(m, par, flip), bc);
    drive_bit(s1, bc);
    if (st2) drive_bit(s2, bc);
    rx = 1'b1;
    if (gap_bits > 0) drive_bit(1'b1, gap_bits * bc);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks_total++;
    if ({data_valid, busy, parity_err, frame_err, break_det, data_out} !== 13'h0)
      $display("FAIL reset_outputs: got %h want 0",
               {data_valid, busy, parity_err, frame_err, break_det, data_out});
    else checks_passed++;
    rst = 1'b1;
    drive_bit(1'b1, 8);
    checks_total++;
    if (busy !== 1'b0 || obs_q.size() != 0)
      $display("FAIL reset_idle: busy=%b strobes=%0d want busy=0 strobes=0", busy, obs_q.size());
    else checks_passed++;
  endtask

  task automatic test_8n1();
    logic [11:0] exp, got;
    obs_q.delete();
    cur_div = 26;
    exp = model_frame(8'hA5, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'hA5, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    checks_total++;
    if (obs_q.size() != 1) $display("FAIL 8n1_strobes: got %0d want 1", obs_q.size());
    else checks_passed++;
    got = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
    checks_total++;
    if (got !== exp) $display("FAIL 8n1_frame: got %h want %h", got, exp);
    else checks_passed++;
    $display("8n1 frame 0xa5: record %h", got);
  endtask

  task automatic test_parity_7e1();
    logic [11:0] exp, got;
    cur_div = 5;
    for (int k = 0; k < 2; k++) begin
      obs_q.delete();
      exp = model_frame(8'h35, 2'b10, 2'b10, 1'b0, k[0], 1'b1, 1'b1);
      send_frame(8'h35, 2'b10, 2'b10, 1'b0, k[0], 1'b1, 1'b1, 1);
      got = (obs_q.size() == 1) ? obs_q.pop_front() : 12'hxxx;
      checks_total++;
      if (got !== exp) $display("FAIL 7e1_flip%0d: got %h want %h", k, got, exp);
      else checks_passed++;
      $display("7e1 frame 0x35 flip=%0d: record %h", k, got);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp, got;
    cur_div = 4;
    obs_q.delete();
    for (int k = 0; k < 3; k++) begin
      exp = model_frame(8'h1F, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1);
      send_frame(8'h1F, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 0);
      got = (obs_q.size() == 1) ? obs_q.pop_front() : 12'hxxx;
      checks_total++;
      if (got !== exp) $display("FAIL 5o2_b2b%0d: got %h want %h", k, got, exp);
      else checks_passed++;
      $display("5o2 back-to-back frame %0d: record %h", k, got);
    end
    drive_bit(1'b1, OS * (cur_div + 1));
  endtask

  task automatic test_glitch();
    int bc;
    cur_div = 5;
    bc = OS * (cur_div + 1);
    obs_q.delete();
    baud_div = DIV_W'(cur_div);
    drive_bit(1'b0, 4 * (cur_div + 1));
    checks_total++;
    if (busy !== 1'b1) $display("FAIL glitch_busy_rise: got %b want 1", busy);
    else checks_passed++;
    drive_bit(1'b1, bc - 4 * (cur_div + 1) + 12);
    checks_total++;
    if (busy !== 1'b0 || obs_q.size() != 0)
      $display("FAIL glitch_reject: busy=%b strobes=%0d want busy=0 strobes=0", busy, obs_q.size());
    else checks_passed++;
    $display("glitch: busy=%b strobes=%0d", busy, obs_q.size());
  endtask

  task automatic test_frame_break();
    logic [11:0] exp, got;
    logic [7:0] d;
    cur_div = 6;
    for (int k = 0; k < 2; k++) begin
      obs_q.delete();
      d = (k == 0) ? 8'h81 : 8'h00;
      exp = model_frame(d, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(d, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1);
      got = (obs_q.size() == 1) ? obs_q.pop_front() : 12'hxxx;
      checks_total++;
      if (got !== exp) $display("FAIL stop0_frame%0d: got %h want %h", k, got, exp);
      else checks_passed++;
      $display("stop-0 frame %h: record %h", d, got);
    end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] exp, got;
    logic [7:0] d;
    int bc;
    cur_div = 5;
    bc = OS * (cur_div + 1);
    d = 8'h5A;
    obs_q.delete();
    baud_div = DIV_W'(cur_div);
    cfg_data_bits = 2'b11;
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b0;
    drive_bit(1'b0, bc);
    for (int i = 0; i < 3; i++) drive_bit(d[i], bc);
    drive_bit(d[3], bc / 2);
    rst = 1'b0;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks_total++;
    if ({data_valid, busy, parity_err, frame_err, break_det, data_out} !== 13'h0)
      $display("FAIL midframe_reset_outputs: got %h want 0",
               {data_valid, busy, parity_err, frame_err, break_det, data_out});
    else checks_passed++;
    rst = 1'b1;
    drive_bit(1'b1, 2 * bc);
    checks_total++;
    if (obs_q.size() != 0 || busy !== 1'b0)
      $display("FAIL midframe_abort: strobes=%0d busy=%b want 0 0", obs_q.size(), busy);
    else checks_passed++;
    exp = model_frame(8'h3C, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h3C, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    got = (obs_q.size() == 1) ? obs_q.pop_front() : 12'hxxx;
    checks_total++;
    if (got !== exp) $display("FAIL after_reset_frame: got %h want %h", got, exp);
    else checks_passed++;
    $display("after mid-frame reset, frame 0x3c: record %h", got);
  endtask

  task automatic test_random();
    logic [11:0] exp, got;
    logic [7:0] d;
    logic [1:0] db, par;
    logic st2, flip, s1, s2, last_stop;
    int gap;
    obs_q.delete();
    for (int k = 0; k < 12; k++) begin
      cur_div   = $urandom_range(2, 8);
      d         = 8'($urandom);
      db        = 2'($urandom);
      par       = 2'($urandom);
      st2       = 1'($urandom);
      flip      = ($urandom_range(0, 3) == 0);
      s1        = ($urandom_range(0, 4) != 0);
      s2        = ($urandom_range(0, 4) != 0);
      last_stop = st2 ? s2 : s1;
      // A low final stop bit needs idle time before the next start can show a fresh edge.
      gap       = last_stop ? $urandom_range(0, 1) : 1;
      exp = model_frame(d, db, par, st2, flip, s1, s2);
      send_frame(d, db, par, st2, flip, s1, s2, gap);
      got = (obs_q.size() == 1) ? obs_q.pop_front() : 12'hxxx;
      obs_q.delete();
      checks_total++;
      if (got !== exp)
        $display("FAIL random%0d: got %h want %h (d=%h db=%0d par=%0d st2=%b flip=%b s1=%b s2=%b div=%0d)",
                 k, got, exp, d, db, par, st2, flip, s1, s2, cur_div);
      else checks_passed++;
      $display("random %0d: d=%h db=%0d par=%0d st2=%b record %h", k, d, db, par, st2, got);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity_7e1();
    test_back_to_back();
    test_glitch();
    test_frame_break();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
